// File: rtl/page_table_walker.sv
// Two-level hardware page-table walker: services TLB misses over a single-outstanding
// memory read port and produces either a one-cycle TLB fill or a one-cycle fault.
module page_table_walker #(
    parameter int VPN_WIDTH = 20,
    parameter int PPN_WIDTH = 20,
    parameter int PTE_WIDTH = 32,
    localparam int PA_WIDTH = PPN_WIDTH + 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req_valid,
    input  logic [VPN_WIDTH-1:0] i_vpn,
    input  logic                 i_miss,
    input  logic [PPN_WIDTH-1:0] i_root_ppn,
    output logic                 o_busy,
    output logic                 o_mem_req,
    output logic [PA_WIDTH-1:0]  o_mem_addr,
    input  logic                 i_mem_ready,
    input  logic                 i_mem_valid,
    input  logic [PTE_WIDTH-1:0] i_mem_data,
    output logic                 o_fill_en,
    output logic [VPN_WIDTH-1:0] o_fill_vpn,
    output logic [PPN_WIDTH-1:0] o_fill_ppn,
    output logic                 o_fault
);

    localparam int IDX_WIDTH = VPN_WIDTH / 2;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L2_REQ,
        L2_WAIT,
        FILL,
        FAULT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [VPN_WIDTH-1:0] vpn_q;
    logic [PPN_WIDTH-1:0] table_ppn_q;
    logic [PPN_WIDTH-1:0] fill_ppn_q;

    logic [IDX_WIDTH-1:0] idx1;
    logic [IDX_WIDTH-1:0] idx0;
    logic [IDX_WIDTH-1:0] idx_sel;
    logic [PA_WIDTH-1:0]  idx_offset;

    logic                 pte_valid;
    logic                 pte_leaf;
    logic [PPN_WIDTH-1:0] pte_ppn;
    logic                 pte_aligned;
    logic [PPN_WIDTH-1:0] superpage_ppn;
    logic                 start_walk;
    logic                 unused_pte;

    assign idx1          = vpn_q[VPN_WIDTH-1:IDX_WIDTH];
    assign idx0          = vpn_q[IDX_WIDTH-1:0];
    assign pte_valid     = i_mem_data[0];
    assign pte_leaf      = i_mem_data[1];
    assign pte_ppn       = i_mem_data[10 +: PPN_WIDTH];
    assign pte_aligned   = (pte_ppn[IDX_WIDTH-1:0] == '0);
    assign superpage_ppn = {pte_ppn[PPN_WIDTH-1:IDX_WIDTH], idx0};
    assign start_walk    = i_req_valid && i_miss;
    assign unused_pte    = ^i_mem_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_walk) state_d = L1_REQ;
            L1_REQ:  if (i_mem_ready) state_d = L1_WAIT;
            L1_WAIT: begin
                if (i_mem_valid) begin
                    if (!pte_valid)       state_d = FAULT;
                    else if (!pte_leaf)   state_d = L2_REQ;
                    else if (!pte_aligned) state_d = FAULT;
                    else                  state_d = FILL;
                end
            end
            L2_REQ:  if (i_mem_ready) state_d = L2_WAIT;
            L2_WAIT: begin
                if (i_mem_valid) begin
                    state_d = (pte_valid && pte_leaf) ? FILL : FAULT;
                end
            end
            FILL:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The table pointer starts as the root and is replaced by the level-1 pointer PTE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpn_q       <= '0;
            table_ppn_q <= '0;
            fill_ppn_q  <= '0;
        end else begin
            if (state_q == IDLE && start_walk) begin
                vpn_q       <= i_vpn;
                table_ppn_q <= i_root_ppn;
            end
            if (state_q == L1_WAIT && i_mem_valid && pte_valid) begin
                if (!pte_leaf) begin
                    table_ppn_q <= pte_ppn;
                end else if (pte_aligned) begin
                    fill_ppn_q <= superpage_ppn;
                end
            end
            if (state_q == L2_WAIT && i_mem_valid && pte_valid && pte_leaf) begin
                fill_ppn_q <= pte_ppn;
            end
        end
    end

    always_comb begin
        idx_sel    = (state_q == L2_REQ) ? idx0 : idx1;
        idx_offset = '0;
        idx_offset[IDX_WIDTH+1:0] = {idx_sel, 2'b00};
        o_busy     = (state_q != IDLE);
        o_mem_req  = (state_q == L1_REQ) || (state_q == L2_REQ);
        o_mem_addr = o_mem_req ? ({table_ppn_q, 12'b0} + idx_offset) : '0;
        o_fill_en  = (state_q == FILL);
        o_fault    = (state_q == FAULT);
        o_fill_vpn = vpn_q;
        o_fill_ppn = fill_ppn_q;
    end

endmodule

// File: tb/tb_page_table_walker.sv
// Self-checking bench for page_table_walker: directed walks, randomized page tables and
// a behavioural walk model over a sparse memory image.
module tb_page_table_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic [19:0] i_vpn;
    logic        i_miss;
    logic [19:0] i_root_ppn;
    logic        o_busy;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_data;
    logic        o_fill_en;
    logic [19:0] o_fill_vpn;
    logic [19:0] o_fill_ppn;
    logic        o_fault;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [logic [31:0]];
    logic [19:0] last_fill_ppn = '0;

    page_table_walker dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_vpn       (i_vpn),
        .i_miss      (i_miss),
        .i_root_ppn  (i_root_ppn),
        .o_busy      (o_busy),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ready (i_mem_ready),
        .i_mem_valid (i_mem_valid),
        .i_mem_data  (i_mem_data),
        .o_fill_en   (o_fill_en),
        .o_fill_vpn  (o_fill_vpn),
        .o_fill_ppn  (o_fill_ppn),
        .o_fault     (o_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] addr);
        return mem.exists(addr) ? mem[addr] : 32'h0;
    endfunction

    function automatic logic [31:0] mkPte(input logic [19:0] ppn, input bit leaf, input bit valid);
        logic [31:0] junk;
        junk = $urandom;
        return {junk[31:30], ppn, junk[9:2], leaf, valid};
    endfunction

    // Reference walk: plain arithmetic on the memory image, no notion of cycles.
    function automatic void refWalk(input logic [19:0] vpn, input logic [19:0] root,
                                    output int nreads, output logic [31:0] a1,
                                    output logic [31:0] a2, output bit fault,
                                    output logic [19:0] ppn);
        int unsigned hi, lo, p, pte;
        hi = vpn / 1024;
        lo = vpn % 1024;
        a1 = root * 4096 + hi * 4;
        a2 = 0;
        ppn = 0;
        fault = 0;
        nreads = 1;
        pte = rd(a1);
        p = (pte / 1024) % (1 << 20);
        if (pte % 2 == 0) begin
            fault = 1;
        end else if ((pte / 2) % 2 == 1) begin
            if (p % 1024 != 0) fault = 1;
            else ppn = 20'(p + lo);
        end else begin
            nreads = 2;
            a2 = p * 4096 + lo * 4;
            pte = rd(a2);
            if (pte % 2 == 0 || (pte / 2) % 2 == 0) fault = 1;
            else ppn = 20'((pte / 1024) % (1 << 20));
        end
    endfunction

    // Memory agent for one read: stall acceptance, then return data after a delay.
    task automatic serveRead(input logic [31:0] exp_addr, input int rdly, input int vdly);
        for (int i = 0; i < rdly; i++) begin
            checkOutput("mem_req_stall", o_mem_req, 1);
            checkOutput("mem_addr_stall", o_mem_addr, exp_addr);
            i_mem_ready = 1'b0;
            step();
        end
        checkOutput("mem_req", o_mem_req, 1);
        checkOutput("mem_addr", o_mem_addr, exp_addr);
        checkOutput("busy_walk", o_busy, 1);
        i_mem_ready = 1'b1;
        step();
        i_mem_ready = 1'b0;
        for (int i = 0; i < vdly; i++) begin
            checkOutput("mem_req_wait", o_mem_req, 0);
            checkOutput("no_pulse_wait", {o_fill_en, o_fault}, 0);
            step();
        end
        checkOutput("mem_req_resp", o_mem_req, 0);
        i_mem_valid = 1'b1;
        i_mem_data  = rd(exp_addr);
        step();
        i_mem_valid = 1'b0;
        i_mem_data  = $urandom;
    endtask

    task automatic applyStimulus(input logic [19:0] vpn, input logic [19:0] root,
                                 input int r1, input int v1, input int r2, input int v2);
        int nreads;
        logic [31:0] a1, a2;
        bit fault;
        logic [19:0] ppn;
        refWalk(vpn, root, nreads, a1, a2, fault, ppn);
        i_req_valid = 1'b1;
        i_miss      = 1'b1;
        i_vpn       = vpn;
        i_root_ppn  = root;
        step();
        checkOutput("busy_start", o_busy, 1);
        i_vpn      = 20'($urandom);
        i_root_ppn = 20'($urandom);
        serveRead(a1, r1, v1);
        if (nreads == 2) serveRead(a2, r2, v2);
        i_req_valid = 1'b0;
        i_miss      = 1'b0;
        checkOutput("fill_en", o_fill_en, !fault);
        checkOutput("fault", o_fault, fault);
        checkOutput("busy_end", o_busy, 1);
        checkOutput("mem_req_end", o_mem_req, 0);
        checkOutput("fill_vpn", o_fill_vpn, vpn);
        if (!fault) last_fill_ppn = ppn;
        checkOutput("fill_ppn", o_fill_ppn, last_fill_ppn);
        step();
        checkOutput("busy_after", o_busy, 0);
        checkOutput("pulse_after", {o_fill_en, o_fault}, 0);
        checkOutput("fill_vpn_hold", o_fill_vpn, vpn);
        checkOutput("fill_ppn_hold", o_fill_ppn, last_fill_ppn);
    endtask

    initial begin
        logic [19:0] vpn, root, p;
        logic [31:0] a1, a2;
        int kind;
        rst = 1'b1;
        i_req_valid = 1'b0;
        i_vpn = '0;
        i_miss = 1'b0;
        i_root_ppn = '0;
        i_mem_ready = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_data = '0;
        step();
        step();
        checkOutput("reset_outputs", {o_busy, o_mem_req, o_fill_en, o_fault}, 0);
        checkOutput("reset_addr", o_mem_addr, 0);
        checkOutput("reset_fill", {o_fill_vpn, o_fill_ppn}, 0);
        rst = 1'b0;
        step();

        $display("[TB] hit in idle");
        i_req_valid = 1'b1;
        i_miss = 1'b0;
        i_vpn = 20'h12345;
        step();
        checkOutput("hit_idle_busy", o_busy, 0);
        step();
        checkOutput("hit_idle_busy2", o_busy, 0);
        i_req_valid = 1'b0;

        $display("[TB] two-level walk");
        mem[32'h0010_0120] = 32'h0020_0401;
        mem[32'h0080_1D14] = 32'h0ABC_D403;
        applyStimulus(20'h12345, 20'h00100, 0, 0, 0, 0);
        checkOutput("two_level_ppn", o_fill_ppn, 32'h2AF35);

        $display("[TB] superpage");
        mem[32'h0030_0120] = 32'h1000_0003;
        applyStimulus(20'h12345, 20'h00300, 0, 0, 0, 0);
        checkOutput("superpage_ppn", o_fill_ppn, 32'h40345);

        $display("[TB] faults");
        applyStimulus(20'h12345, 20'h00500, 0, 0, 0, 0);
        mem[32'h0060_0120] = 32'h001C_0001;
        mem[32'h0070_0D14] = 32'h048D_1401;
        applyStimulus(20'h12345, 20'h00600, 0, 0, 0, 0);
        mem[32'h0080_0120] = 32'h1000_0403;
        applyStimulus(20'h12345, 20'h00800, 0, 0, 0, 0);
        checkOutput("fault_keeps_ppn", o_fill_ppn, 32'h40345);

        $display("[TB] backpressure");
        applyStimulus(20'h12345, 20'h00100, 3, 4, 0, 0);
        checkOutput("bp_ppn", o_fill_ppn, 32'h2AF35);

        $display("[TB] reset mid-walk");
        i_req_valid = 1'b1;
        i_miss = 1'b1;
        i_vpn = 20'h12345;
        i_root_ppn = 20'h00100;
        step();
        serveRead(32'h0010_0120, 0, 0);
        checkOutput("l2_addr", o_mem_addr, 32'h0080_1D14);
        i_mem_ready = 1'b1;
        step();
        i_mem_ready = 1'b0;
        i_req_valid = 1'b0;
        i_miss = 1'b0;
        checkOutput("l2_wait_busy", o_busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_flags", {o_busy, o_mem_req, o_fill_en, o_fault}, 0);
        checkOutput("rst_mid_addr", o_mem_addr, 0);
        checkOutput("rst_mid_fill", {o_fill_vpn, o_fill_ppn}, 0);
        last_fill_ppn = '0;
        step();
        rst = 1'b0;
        i_mem_valid = 1'b1;
        i_mem_data = 32'h0ABC_D403;
        step();
        i_mem_valid = 1'b0;
        checkOutput("late_resp_flags", {o_busy, o_fill_en, o_fault}, 0);
        step();
        checkOutput("late_resp_flags2", {o_busy, o_fill_en, o_fault}, 0);
        checkOutput("late_resp_ppn", o_fill_ppn, 0);
        applyStimulus(20'h12345, 20'h00100, 0, 0, 0, 0);

        $display("[TB] randomized walks");
        for (int n = 0; n < 40; n++) begin
            vpn  = 20'($urandom);
            root = 20'($urandom);
            a1   = {root, 12'h0} + {20'h0, vpn[19:10], 2'b00};
            kind = $urandom_range(0, 3);
            p    = 20'($urandom);
            case (kind)
                0: mem[a1] = mkPte(p, 1'($urandom), 1'b0);
                1: begin
                    mem[a1] = mkPte(p, 1'b0, 1'b1);
                    a2 = {p, 12'h0} + {20'h0, vpn[9:0], 2'b00};
                    mem[a2] = ($urandom_range(0, 3) != 0) ? mkPte(20'($urandom), 1'b1, 1'b1)
                                                         : mkPte(20'($urandom), 1'($urandom), 1'($urandom));
                end
                2: mem[a1] = mkPte({p[19:10], 10'h0}, 1'b1, 1'b1);
                default: mem[a1] = mkPte({p[19:10], 10'($urandom_range(1, 1023))}, 1'b1, 1'b1);
            endcase
            applyStimulus(vpn, root, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
